// File: rtl/stack_op_sequencer_if.sv
// Control bundle between the instruction front end and the CALL/RET sequencer.
interface stack_op_sequencer_if #(
   parameter int DEPTH_W = 4
);
   logic               iCall;
   logic               iRet;
   logic               iAluCmdDec;
   logic               iMemWait;
   logic               oAluCmd;
   logic               oCallCmd;
   logic               oAluOp;
   logic               oSpWe;
   logic               oMemWe;
   logic               oMemRe;
   logic [1:0]         oPcSel;
   logic               oBusy;
   logic               oDone;
   logic               oFault;
   logic [1:0]         oFaultCode;
   logic [DEPTH_W-1:0] oDepth;

   // Front end / decoder side
   modport master (
      output iCall, iRet, iAluCmdDec, iMemWait,
      input  oAluCmd, oCallCmd, oAluOp, oSpWe, oMemWe, oMemRe,
             oPcSel, oBusy, oDone, oFault, oFaultCode, oDepth
   );

   // Sequencer side
   modport slave (
      input  iCall, iRet, iAluCmdDec, iMemWait,
      output oAluCmd, oCallCmd, oAluOp, oSpWe, oMemWe, oMemRe,
             oPcSel, oBusy, oDone, oFault, oFaultCode, oDepth
   );
endinterface

// File: rtl/stack_op_sequencer.sv
// CALL/RET micro-sequencer: steers SP update, return-address push/pop and PC
// selection, tracks nesting depth and flags overflow/underflow requests.
module stack_op_sequencer #(
   parameter int DEPTH_W = 4
) (
   input logic                 iClk,
   input logic                 iRst_n,
   stack_op_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, C_DEC, C_PUSH, C_JUMP, R_LOAD, R_INC, R_JUMP
   } state_t;

   localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;

   state_t             state;
   state_t             stateNext;
   logic [DEPTH_W-1:0] depth;
   logic               fault;
   logic [1:0]         faultCode;
   logic               callReq;
   logic               retReq;
   logic               callRej;
   logic               retRej;

   // Request qualification; CALL wins when both are raised
   always_comb begin
      callReq = (state == IDLE) && bus.iCall;
      retReq  = (state == IDLE) && !bus.iCall && bus.iRet;
      callRej = callReq && (depth == MAX_DEPTH);
      retRej  = retReq && (depth == '0);
   end

   // State register
   always_ff @(posedge iClk) begin
      if (!iRst_n) state <= IDLE;
      else         state <= stateNext;
   end

   // Nesting depth and fault reporting
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         depth     <= '0;
         fault     <= 1'b0;
         faultCode <= 2'b00;
      end else begin
         fault <= callRej || retRej;
         if (callRej)     faultCode <= 2'b01;
         else if (retRej) faultCode <= 2'b10;
         if (state == C_JUMP)      depth <= depth + 1'b1;
         else if (state == R_JUMP) depth <= depth - 1'b1;
      end
   end

   // Next-state and state-decoded strobes
   always_comb begin
      stateNext    = state;
      bus.oAluCmd  = 1'b0;
      bus.oCallCmd = 1'b0;
      bus.oAluOp   = 1'b0;
      bus.oSpWe    = 1'b0;
      bus.oMemWe   = 1'b0;
      bus.oMemRe   = 1'b0;
      bus.oPcSel   = 2'b00;
      bus.oBusy    = 1'b1;
      bus.oDone    = 1'b0;
      unique case (state)
         IDLE: begin
            bus.oAluCmd = bus.iAluCmdDec;
            bus.oBusy   = 1'b0;
            if (callReq && !callRej)    stateNext = C_DEC;
            else if (retReq && !retRej) stateNext = R_LOAD;
         end
         C_DEC: begin
            bus.oCallCmd = 1'b1;
            bus.oSpWe    = 1'b1;
            stateNext    = C_PUSH;
         end
         C_PUSH: begin
            bus.oMemWe = 1'b1;
            if (!bus.iMemWait) stateNext = C_JUMP;
         end
         C_JUMP: begin
            bus.oPcSel = 2'b01;
            bus.oDone  = 1'b1;
            stateNext  = IDLE;
         end
         R_LOAD: begin
            bus.oMemRe = 1'b1;
            if (!bus.iMemWait) stateNext = R_INC;
         end
         R_INC: begin
            bus.oCallCmd = 1'b1;
            bus.oAluOp   = 1'b1;
            bus.oSpWe    = 1'b1;
            stateNext    = R_JUMP;
         end
         R_JUMP: begin
            bus.oPcSel = 2'b10;
            bus.oDone  = 1'b1;
            stateNext  = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign bus.oFault     = fault;
   assign bus.oFaultCode = faultCode;
   assign bus.oDepth     = depth;
endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: directed CALL/RET scenarios against a
// micro-op queue model, plus hand-computed literal expectations.
module tb_stack_op_sequencer;
   localparam int DW   = 2;
   localparam int MAXD = (1 << DW) - 1;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   stack_op_sequencer_if #(.DEPTH_W(DW)) bus ();

   stack_op_sequencer #(.DEPTH_W(DW)) dut (
      .iClk  (clk),
      .iRst_n(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: a request in IDLE enqueues its three micro-ops; memory ops hold
   // while iMemWait is high; jumps apply the depth change as they retire.
   typedef enum int {U_SPDEC, U_WRITE, U_JUMPTGT, U_READ, U_SPINC, U_JUMPRET} uop_t;
   uop_t mQ[$];
   int   mDepth   = 0;
   bit   mFault   = 0;
   int   mCode    = 0;
   bit   started  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      started = 1;
      if (!rst_n) begin
         mQ.delete();
         mDepth = 0;
         mFault = 0;
         mCode  = 0;
      end else begin
         mFault = 0;
         if (mQ.size() == 0) begin
            if (bus.iCall) begin
               if (mDepth == MAXD) begin mFault = 1; mCode = 1; end
               else mQ = '{U_SPDEC, U_WRITE, U_JUMPTGT};
            end else if (bus.iRet) begin
               if (mDepth == 0) begin mFault = 1; mCode = 2; end
               else mQ = '{U_READ, U_SPINC, U_JUMPRET};
            end
         end else if (!((mQ[0] == U_WRITE || mQ[0] == U_READ) && bus.iMemWait)) begin
            if (mQ[0] == U_JUMPTGT)      mDepth++;
            else if (mQ[0] == U_JUMPRET) mDepth--;
            void'(mQ.pop_front());
         end
      end
   end

   // Per-cycle comparison of every output against the model
   initial forever begin
      logic [15:0] act, exp;
      bit   idle;
      uop_t h;
      @(negedge clk);
      if (started) begin
         idle = (mQ.size() == 0);
         h    = idle ? U_SPDEC : mQ[0];
         exp = {idle ? bus.iAluCmdDec : 1'b0,
                !idle && (h == U_SPDEC || h == U_SPINC),
                !idle && (h == U_SPINC),
                !idle && (h == U_SPDEC || h == U_SPINC),
                !idle && (h == U_WRITE),
                !idle && (h == U_READ),
                (!idle && h == U_JUMPTGT) ? 2'b01 : (!idle && h == U_JUMPRET) ? 2'b10 : 2'b00,
                !idle,
                !idle && (h == U_JUMPTGT || h == U_JUMPRET),
                mFault,
                2'(mCode),
                2'(mDepth),
                1'b0};
         act = {bus.oAluCmd, bus.oCallCmd, bus.oAluOp, bus.oSpWe, bus.oMemWe, bus.oMemRe,
                bus.oPcSel, bus.oBusy, bus.oDone, bus.oFault, bus.oFaultCode, bus.oDepth, 1'b0};
         chk("cycle outputs", act, exp);
         chk("alucmd/callcmd exclusive", bus.oAluCmd & bus.oCallCmd, 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and let it run to IDLE with no memory wait
   task automatic runSeq(input bit isCall);
      bus.iCall = isCall;
      bus.iRet  = !isCall;
      tick();
      bus.iCall = 0;
      bus.iRet  = 0;
      for (int k = 0; k < 20 && bus.oBusy; k++) tick();
      chk("sequence completes", bus.oBusy, 0);
   endtask

   initial begin
      int doneAt, reCnt;
      rst_n          = 0;
      bus.iCall      = 0;
      bus.iRet       = 0;
      bus.iAluCmdDec = 0;
      bus.iMemWait   = 0;
      tick(); tick();
      chk("reset busy", bus.oBusy, 0);
      chk("reset depth", bus.oDepth, 0);
      chk("reset faultcode", bus.oFaultCode, 0);
      rst_n = 1;
      bus.iAluCmdDec = 1; #1;
      chk("idle alucmd follows dec", bus.oAluCmd, 1);
      bus.iAluCmdDec = 0;

      // Zero-wait CALL from depth 0
      bus.iCall = 1;
      tick();
      bus.iCall = 0;
      chk("c_dec callcmd", bus.oCallCmd, 1);
      chk("c_dec spwe", bus.oSpWe, 1);
      chk("c_dec aluop", bus.oAluOp, 0);
      tick();
      chk("c_push memwe", bus.oMemWe, 1);
      tick();
      chk("c_jump pcsel", bus.oPcSel, 2'b01);
      chk("c_jump done", bus.oDone, 1);
      tick();
      chk("call depth", bus.oDepth, 1);

      // RET at depth 1 with two wait cycles; iCall raised mid-sequence is ignored
      bus.iRet = 1;
      bus.iMemWait = 1;
      doneAt = 0;
      reCnt = 0;
      for (int cyc = 1; cyc <= 12 && doneAt == 0; cyc++) begin
         tick();
         bus.iRet = 0;
         bus.iCall = (cyc == 2);
         if (bus.oMemRe) reCnt++;
         if (cyc == 4) begin
            chk("r_inc aluop", bus.oAluOp, 1);
            chk("r_inc callcmd", bus.oCallCmd, 1);
         end
         if (bus.oDone) begin
            doneAt = cyc;
            chk("r_jump pcsel", bus.oPcSel, 2'b10);
         end
         if (cyc == 3) bus.iMemWait = 0;
      end
      bus.iCall = 0;
      chk("ret done latency", doneAt, 5);
      chk("ret memre cycles", reCnt, 3);
      tick();
      chk("ret depth", bus.oDepth, 0);
      chk("ret no fault", bus.oFaultCode, 0);

      // Simultaneous CALL+RET: CALL wins, no fault
      bus.iCall = 1;
      bus.iRet  = 1;
      tick();
      bus.iCall = 0;
      bus.iRet  = 0;
      chk("both callcmd", bus.oCallCmd, 1);
      chk("both no fault", bus.oFault, 0);
      for (int k = 0; k < 10 && bus.oBusy; k++) tick();
      chk("both depth", bus.oDepth, 1);

      // Fill to max, then overflow
      runSeq(1);
      runSeq(1);
      chk("depth at max", bus.oDepth, MAXD);
      bus.iCall = 1;
      tick();
      bus.iCall = 0;
      chk("overflow pulse", bus.oFault, 1);
      chk("overflow code", bus.oFaultCode, 2'b01);
      chk("overflow busy", bus.oBusy, 0);
      tick();
      chk("overflow pulse ends", bus.oFault, 0);
      chk("overflow code held", bus.oFaultCode, 2'b01);
      chk("overflow depth kept", bus.oDepth, MAXD);

      // Drain, then underflow
      runSeq(0);
      runSeq(0);
      runSeq(0);
      chk("drained depth", bus.oDepth, 0);
      bus.iRet = 1;
      tick();
      bus.iRet = 0;
      chk("underflow pulse", bus.oFault, 1);
      chk("underflow code", bus.oFaultCode, 2'b10);
      chk("underflow busy", bus.oBusy, 0);

      // Reset during C_PUSH at depth 2
      runSeq(1);
      runSeq(1);
      bus.iCall = 1;
      tick();
      bus.iCall = 0;
      bus.iMemWait = 1;
      tick();
      chk("push before reset", bus.oMemWe, 1);
      rst_n = 0;
      tick();
      chk("abort memwe", bus.oMemWe, 0);
      chk("abort busy", bus.oBusy, 0);
      chk("abort depth", bus.oDepth, 0);
      chk("abort done", bus.oDone, 0);
      chk("abort faultcode", bus.oFaultCode, 0);
      rst_n = 1;
      bus.iMemWait = 0;
      tick();
      chk("abort stays idle", bus.oBusy, 0);
      chk("abort no late done", bus.oDone, 0);

      // Mixed traffic, checked cycle by cycle against the model
      for (int n = 0; n < 400; n++) begin
         bus.iCall      = ($urandom_range(3) == 0);
         bus.iRet       = ($urandom_range(3) == 0);
         bus.iAluCmdDec = 1'($urandom_range(1));
         bus.iMemWait   = ($urandom_range(2) == 0);
         rst_n          = ($urandom_range(79) != 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/stack_op_sequencer.md
STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

Interface
REQ-001 Parameter DEPTH_W, default 4: width of the call-nesting depth counter; maximum depth is 2^DEPTH_W-1.
REQ-002 iClk  input  1  single clock; all state updates on rising edge.
REQ-003 iRst_n  input  1  reset, synchronous and active-low.
REQ-004 iCall  input  1  decoded CALL request, sampled only in IDLE.
REQ-005 iRet  input  1  decoded RET request, sampled only in IDLE.
REQ-006 iAluCmdDec  input  1  decoder's immediate-select for ordinary instructions.
REQ-007 iMemWait  input  1  data memory not ready; extends PUSH/LOAD states.
REQ-008 oAluCmd  output  1  ALU source-B immediate select (to operand mux).
REQ-009 oCallCmd  output  1  ALU source-B constant -1 select (to operand mux).
REQ-010 oAluOp  output  1  0 = ADD, 1 = SUB.
REQ-011 oSpWe  output  1  stack-pointer register write enable.
REQ-012 oMemWe / oMemRe  output  1 each  data-memory write / read strobe.
REQ-013 oPcSel  output  2  00 = PC+1, 01 = call target, 10 = loaded return address.
REQ-014 oBusy  output  1  high in every state except IDLE; front end stalls.
REQ-015 oDone  output  1  one-cycle completion pulse.
REQ-016 oFault  output  1  one-cycle pulse on rejected request; oFaultCode  output  2  01 = overflow, 10 = underflow, held until next fault.
REQ-017 oDepth  output  DEPTH_W  current nesting depth.

Function
REQ-018 States: IDLE, C_DEC, C_PUSH, C_JUMP, R_LOAD, R_INC, R_JUMP; all outputs except oFault/oFaultCode/oDepth are decoded from current state only.
REQ-019 IDLE: oAluCmd = iAluCmdDec, all other strobes 0, oPcSel = 00.
REQ-020 IDLE with iCall=1 and oDepth < max -> C_DEC; iCall has priority when iCall and iRet are both 1.
REQ-021 IDLE with iRet=1 (iCall=0) and oDepth != 0 -> R_LOAD.
REQ-022 IDLE with iCall=1 and oDepth = max: stay IDLE, oFault=1 next cycle, oFaultCode=01, depth unchanged.
REQ-023 IDLE with iRet=1, iCall=0, oDepth = 0: stay IDLE, oFault=1 next cycle, oFaultCode=10.
REQ-024 C_DEC (1 cycle): oCallCmd=1, oAluOp=ADD, oSpWe=1 (SP <- SP-1) -> C_PUSH.
REQ-025 C_PUSH: oMemWe=1; remain while iMemWait=1; -> C_JUMP when iMemWait=0.
REQ-026 C_JUMP (1 cycle): oPcSel=01, oDone=1, depth increments -> IDLE.
REQ-027 R_LOAD: oMemRe=1; remain while iMemWait=1; -> R_INC when iMemWait=0.
REQ-028 R_INC (1 cycle): oCallCmd=1, oAluOp=SUB, oSpWe=1 (SP <- SP+1) -> R_JUMP.
REQ-029 R_JUMP (1 cycle): oPcSel=10, oDone=1, depth decrements -> IDLE.
REQ-030 oAluCmd SHALL be 0 in every non-IDLE state; oAluCmd and oCallCmd never both 1.
REQ-031 Zero-wait latency: request in IDLE at edge N -> oDone high in cycle N+3; each iMemWait cycle adds one.
REQ-032 iCall/iRet outside IDLE are ignored and not queued.
REQ-033 Depth counter never wraps; it only changes in C_JUMP/R_JUMP.

Reset
REQ-034 iRst_n=0 at a rising edge: state IDLE, oDepth=0, oFault=0, oFaultCode=00; all strobes 0, oPcSel=00, oBusy=0 from the next cycle, including mid-sequence (aborted sequence is not completed).

Verification
REQ-035 CALL, iMemWait=0, depth 0: C_DEC (oCallCmd=1, oSpWe=1), C_PUSH (oMemWe=1), C_JUMP (oPcSel=01, oDone=1); oDepth=1 afterwards.
REQ-036 RET at depth 1 with iMemWait=1 for 2 cycles: oMemRe held 3 cycles, then R_INC (oAluOp=1, oCallCmd=1), oDone 5 cycles after request; oDepth=0.
REQ-037 iCall=iRet=1 in IDLE, depth 0: CALL sequence runs, no fault.
REQ-038 DEPTH_W=2, 3 CALLs then 4th CALL: oFault pulse, oFaultCode=01, oBusy stays 0; RET at depth 0 gives oFaultCode=10.
REQ-039 iRst_n=0 during C_PUSH at depth 2: next cycle IDLE, oMemWe=0, oDepth=0, no oDone.
REQ-040 Across all scenarios: oAluCmd and oCallCmd never simultaneously 1; oAluCmd follows iAluCmdDec only in IDLE.
